// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial IF/LS memory controller on an 8-bit sync-RAM bus.
// Define MEM_CTRL_MISALIGN_CHECK_EN to reject misaligned LS half/word accesses with ls_err.
module mem_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int IO_SEL_HI = 17
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic              rdy_in,
   input  logic              io_buffer_full,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   input  logic              if_flush,
   output logic              if_resp_valid,
   output logic [31:0]       if_rdata,
   input  logic              ls_valid,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic              ls_sign,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_ready,
   output logic              ls_resp_valid,
   output logic [31:0]       ls_rdata,
   output logic              ls_err
);
   typedef enum logic [2:0] {IDLE, RD, WR, IO_WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] addr, byte_a;
   logic [31:0] wdata, data, ext;
   logic [2:0] n, cap, idx;
   logic live, pend, is_ls, sign, err;
   logic acc_ls, acc_if, misalign, io, rd_issue, rd_cap, wr_fire, flush_if, resp;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
   assign misalign = (ls_size == 2'd1 && ls_addr[0]) || (ls_size[1] && ls_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   assign ls_ready = live && state == IDLE && rdy_in;
   assign if_ready = ls_ready && !ls_valid;
   assign acc_ls   = ls_ready && ls_valid;
   assign acc_if   = if_ready && if_valid;
   // a read keeps one byte in flight, so the next address is cap+pend
   assign idx      = cap + {2'b00, pend};
   assign byte_a   = addr + ADDR_W'(idx);
   assign io       = byte_a[IO_SEL_HI -: 2] == 2'b11;
   assign rd_cap   = state == RD && rdy_in && pend;
   assign rd_issue = state == RD && rdy_in && idx < n;
   assign wr_fire  = (state == WR || state == IO_WAIT) && rdy_in && !(io && io_buffer_full);
   assign flush_if = if_flush && !is_ls && state != IDLE;
   assign resp     = state == RESP && rdy_in;
   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (flush_if) state_nxt = IDLE;
      else
         case (state)
            IDLE:        state_nxt = acc_ls ? (misalign ? RESP : ls_we ? WR : RD) : acc_if ? RD : IDLE;
            RD:          state_nxt = (rd_cap && cap + 3'd1 == n) ? RESP : RD;
            WR, IO_WAIT: state_nxt = !rdy_in ? state : wr_fire ? (cap + 3'd1 == n ? RESP : WR) : IO_WAIT;
            RESP:        state_nxt = rdy_in ? IDLE : RESP;
            default:     state_nxt = IDLE;
         endcase
   end
   always_ff @(posedge clk_in or negedge rst_in_n)
      if (!rst_in_n) begin
         live  <= 1'b0;
         addr  <= '0;
         n     <= '0;
         cap   <= '0;
         pend  <= 1'b0;
         is_ls <= 1'b0;
         sign  <= 1'b0;
         err   <= 1'b0;
         wdata <= '0;
         data  <= '0;
      end else begin
         live <= 1'b1;
         if (acc_ls || acc_if) begin
            addr  <= acc_ls ? ls_addr : if_addr;
            n     <= !acc_ls ? 3'd4 : ls_size == 2'd0 ? 3'd1 : ls_size == 2'd1 ? 3'd2 : 3'd4;
            cap   <= '0;
            pend  <= 1'b0;
            is_ls <= acc_ls;
            sign  <= ls_sign;
            err   <= acc_ls && misalign;
            wdata <= ls_wdata;
            data  <= '0;
         end else if (rdy_in) begin
            if (rd_cap) data[{cap[1:0], 3'b000} +: 8] <= mem_din;
            if (rd_cap || wr_fire) cap <= cap + 3'd1;
            pend <= rd_issue;
         end else pend <= 1'b0;
      end
   assign mem_a    = (rd_issue || wr_fire) ? byte_a : '0;
   assign mem_wr   = wr_fire;
   assign mem_dout = wr_fire ? wdata[{cap[1:0], 3'b000} +: 8] : 8'h00;
   assign ext = n == 3'd1 ? {{24{sign & data[7]}}, data[7:0]} :
                n == 3'd2 ? {{16{sign & data[15]}}, data[15:0]} : data;
   assign if_resp_valid = resp && !is_ls && !if_flush;
   assign if_rdata      = if_resp_valid ? data : '0;
   assign ls_resp_valid = resp && is_ls;
   assign ls_rdata      = ls_resp_valid ? ext : '0;
   assign ls_err        = ls_resp_valid && err;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a 1-cycle-latency byte RAM model.
module tb_mem_ctrl;
   logic clk_in = 0, rst_in_n = 0, rdy_in = 1, io_buffer_full = 0;
   logic [7:0] mem_din, mem_dout;
   logic [31:0] mem_a;
   logic mem_wr;
   logic if_valid = 0, if_flush = 0, if_ready, if_resp_valid;
   logic [31:0] if_addr = 0, if_rdata;
   logic ls_valid = 0, ls_we = 0, ls_sign = 0, ls_ready, ls_resp_valid, ls_err;
   logic [1:0] ls_size = 0;
   logic [31:0] ls_addr = 0, ls_wdata = 0, ls_rdata;
   logic [7:0] ram [0:(1<<18)-1];
   logic ld_en = 0;
   logic [17:0] ld_a = 0;
   logic [7:0] ld_d = 0;
   logic [31:0] lg_a [0:31], lg_rd [0:31];
   logic [7:0] lg_do [0:31];
   logic lg_wr [0:31], lg_rv [0:31], lg_rdy [0:31], lg_err [0:31];
   logic ctl_rdy [0:31], ctl_full [0:31], ctl_flush [0:31];
   int checks = 0, failures = 0;

   mem_ctrl dut (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_flush(if_flush),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
      .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size), .ls_sign(ls_sign), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
      .ls_err(ls_err)
   );

   always #5 clk_in = ~clk_in;

   // bytes returned while the bus was handed away are garbage
   always @(posedge clk_in) begin
      mem_din <= rdy_in ? ram[mem_a[17:0]] : 8'hA5;
      if (ld_en) ram[ld_a] <= ld_d;
      else if (mem_wr && rdy_in) ram[mem_a[17:0]] <= mem_dout;
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic poke(input logic [17:0] a, input logic [7:0] d);
      ld_en = 1; ld_a = a; ld_d = d;
      step();
      ld_en = 0;
   endtask

   task automatic clr_ctl();
      for (int c = 0; c < 32; c++) begin
         ctl_rdy[c] = 1; ctl_full[c] = 0; ctl_flush[c] = 0;
      end
   endtask

   // one request presented in cycle 0 only, len cycles logged
   task automatic xfer(input bit ls, input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input int len);
      for (int c = 0; c < len; c++) begin
         if_valid = !ls && c == 0; ls_valid = ls && c == 0;
         ls_we = we; ls_size = sz; ls_sign = sg; ls_addr = a; if_addr = a; ls_wdata = wd;
         rdy_in = ctl_rdy[c]; io_buffer_full = ctl_full[c]; if_flush = ctl_flush[c];
         #1;
         lg_a[c] = mem_a; lg_wr[c] = mem_wr; lg_do[c] = mem_dout; lg_err[c] = ls_err;
         lg_rv[c] = ls ? ls_resp_valid : if_resp_valid;
         lg_rd[c] = ls ? ls_rdata : if_rdata;
         lg_rdy[c] = ls ? ls_ready : if_ready;
         step();
      end
      if_valid = 0; ls_valid = 0; rdy_in = 1; io_buffer_full = 0; if_flush = 0;
      clr_ctl();
   endtask

   function automatic int first_rv(input int len);
      for (int c = 0; c < len; c++) if (lg_rv[c]) return c;
      return -1;
   endfunction

   function automatic int n_rv(input int len);
      int s = 0;
      for (int c = 0; c < len; c++) s += int'(lg_rv[c]);
      return s;
   endfunction

   function automatic int n_wr(input int len);
      int s = 0;
      for (int c = 0; c < len; c++) s += int'(lg_wr[c]);
      return s;
   endfunction

   task automatic test_reset();
      int n;
      #1;
      checks++; if (mem_a !== 0 || mem_wr !== 0 || mem_dout !== 0) begin failures++; $display("FAIL reset_bus got a=%h wr=%b d=%h exp 0/0/0", mem_a, mem_wr, mem_dout); end
      checks++; if (if_ready !== 0 || ls_ready !== 0 || if_resp_valid !== 0 || ls_resp_valid !== 0) begin failures++; $display("FAIL reset_hs got rdy=%b%b rv=%b%b exp 0", if_ready, ls_ready, if_resp_valid, ls_resp_valid); end
      step(); rst_in_n = 1; step(); step();
      xfer(0, 0, 2'd2, 0, 32'h40, 0, 2);
      rst_in_n = 0;
      #1;
      checks++; if (mem_a !== 0 || mem_wr !== 0) begin failures++; $display("FAIL reset_async got a=%h wr=%b exp 0/0", mem_a, mem_wr); end
      checks++; if (if_ready !== 0) begin failures++; $display("FAIL reset_ready got %b exp 0", if_ready); end
      step(); rst_in_n = 1;
      n = 0;
      for (int c = 0; c < 8; c++) begin n += int'(if_resp_valid); step(); end
      checks++; if (n !== 0) begin failures++; $display("FAIL reset_abandon got %0d responses exp 0", n); end
   endtask

   task automatic test_if_fetch();
      xfer(0, 0, 2'd2, 0, 32'h0, 0, 9);
      checks++; if (lg_rdy[0] !== 1) begin failures++; $display("FAIL fetch_ready got %b exp 1", lg_rdy[0]); end
      for (int k = 1; k <= 4; k++) begin
         checks++; if (lg_a[k] !== 32'(k - 1)) begin failures++; $display("FAIL fetch_addr%0d got %h exp %h", k, lg_a[k], k - 1); end
      end
      checks++; if (n_wr(9) !== 0) begin failures++; $display("FAIL fetch_nowr got %0d exp 0", n_wr(9)); end
      checks++; if (first_rv(9) !== 6 || n_rv(9) !== 1) begin failures++; $display("FAIL fetch_resp got cyc=%0d n=%0d exp 6/1", first_rv(9), n_rv(9)); end
      checks++; if (lg_rd[6] !== 32'h00000513) begin failures++; $display("FAIL fetch_data got %h exp 00000513", lg_rd[6]); end
   endtask

   task automatic test_store_load();
      logic [31:0] wd = 32'hDEADBEEF;
      xfer(1, 1, 2'd2, 0, 32'h100, wd, 7);
      for (int k = 1; k <= 4; k++) begin
         checks++; if (lg_wr[k] !== 1 || lg_a[k] !== 32'h100 + 32'(k - 1) || lg_do[k] !== wd[8*(k-1) +: 8])
            begin failures++; $display("FAIL sw_byte%0d got wr=%b a=%h d=%h exp 1/%h/%h", k, lg_wr[k], lg_a[k], lg_do[k], 32'h100 + 32'(k - 1), wd[8*(k-1) +: 8]); end
      end
      checks++; if (n_wr(7) !== 4) begin failures++; $display("FAIL sw_nwr got %0d exp 4", n_wr(7)); end
      checks++; if (first_rv(7) !== 5 || lg_rd[5] !== 0) begin failures++; $display("FAIL sw_resp got cyc=%0d d=%h exp 5/0", first_rv(7), lg_rd[5]); end
      checks++; if ({ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]} !== wd) begin failures++; $display("FAIL sw_ram got %h exp %h", {ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]}, wd); end
      xfer(1, 0, 2'd1, 1, 32'h102, 0, 6);
      checks++; if (first_rv(6) !== 4 || lg_rd[4] !== 32'hFFFFDEAD) begin failures++; $display("FAIL lh_s got cyc=%0d d=%h exp 4/FFFFDEAD", first_rv(6), lg_rd[4]); end
      xfer(1, 0, 2'd1, 0, 32'h102, 0, 6);
      checks++; if (lg_rd[4] !== 32'h0000DEAD) begin failures++; $display("FAIL lhu got %h exp 0000DEAD", lg_rd[4]); end
      xfer(1, 0, 2'd0, 1, 32'h200, 0, 5);
      checks++; if (first_rv(5) !== 3 || lg_rd[3] !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_s got cyc=%0d d=%h exp 3/FFFFFF80", first_rv(5), lg_rd[3]); end
      xfer(1, 0, 2'd0, 0, 32'h200, 0, 5);
      checks++; if (lg_rd[3] !== 32'h00000080) begin failures++; $display("FAIL lbu got %h exp 00000080", lg_rd[3]); end
      xfer(1, 0, 2'd3, 1, 32'h100, 0, 8);
      checks++; if (first_rv(8) !== 6 || lg_rd[6] !== wd) begin failures++; $display("FAIL lw_size3 got cyc=%0d d=%h exp 6/%h", first_rv(8), lg_rd[6], wd); end
   endtask

   task automatic test_io_wait();
      for (int c = 1; c <= 10; c++) ctl_full[c] = 1;
      xfer(1, 1, 2'd0, 0, 32'h30000, 32'h41, 15);
      checks++; if (n_wr(15) !== 1) begin failures++; $display("FAIL io_nwr got %0d exp 1", n_wr(15)); end
      checks++; if (lg_wr[11] !== 1 || lg_a[11] !== 32'h30000 || lg_do[11] !== 8'h41) begin failures++; $display("FAIL io_write got wr=%b a=%h d=%h exp 1/30000/41", lg_wr[11], lg_a[11], lg_do[11]); end
      checks++; if (lg_a[5] !== 0) begin failures++; $display("FAIL io_hold got a=%h exp 0", lg_a[5]); end
      checks++; if (first_rv(15) !== 12 || n_rv(15) !== 1) begin failures++; $display("FAIL io_resp got cyc=%0d n=%0d exp 12/1", first_rv(15), n_rv(15)); end
   endtask

   task automatic test_back_to_back();
      int ls_rc = -1, if_acc = -1, if_rc = -1;
      logic [31:0] ls_d = 0, if_d = 0;
      logic ifr0 = 1;
      for (int c = 0; c < 14; c++) begin
         ls_valid = c == 0; ls_we = 0; ls_size = 0; ls_sign = 0; ls_addr = 32'h200;
         if_valid = if_acc < 0; if_addr = 0;
         #1;
         if (c == 0) ifr0 = if_ready;
         if (if_valid && if_ready) if_acc = c;
         if (ls_resp_valid && ls_rc < 0) begin ls_rc = c; ls_d = ls_rdata; end
         if (if_resp_valid && if_rc < 0) begin if_rc = c; if_d = if_rdata; end
         step();
      end
      if_valid = 0; ls_valid = 0;
      checks++; if (ifr0 !== 0) begin failures++; $display("FAIL prio_ifready got %b exp 0", ifr0); end
      checks++; if (ls_rc !== 3 || ls_d !== 32'h80) begin failures++; $display("FAIL prio_ls got cyc=%0d d=%h exp 3/80", ls_rc, ls_d); end
      checks++; if (if_acc !== 4) begin failures++; $display("FAIL prio_ifacc got %0d exp 4", if_acc); end
      checks++; if (if_rc !== 10 || if_d !== 32'h513) begin failures++; $display("FAIL prio_if got cyc=%0d d=%h exp 10/513", if_rc, if_d); end
   endtask

   task automatic test_rdy_stall();
      for (int c = 2; c <= 4; c++) ctl_rdy[c] = 0;
      xfer(0, 0, 2'd2, 0, 32'h40, 0, 12);
      checks++; if (lg_a[1] !== 32'h40 || lg_a[5] !== 32'h40 || lg_a[6] !== 32'h41) begin failures++; $display("FAIL stall_reissue got %h %h %h exp 40 40 41", lg_a[1], lg_a[5], lg_a[6]); end
      checks++; if (n_wr(12) !== 0) begin failures++; $display("FAIL stall_nowr got %0d exp 0", n_wr(12)); end
      checks++; if (first_rv(12) !== 10 || lg_rd[10] !== 32'h44332211) begin failures++; $display("FAIL stall_rd got cyc=%0d d=%h exp 10/44332211", first_rv(12), lg_rd[10]); end
      ctl_rdy[2] = 0; ctl_rdy[3] = 0;
      xfer(1, 1, 2'd2, 0, 32'h180, 32'h11223344, 9);
      checks++; if (n_wr(9) !== 4 || lg_wr[2] !== 0 || first_rv(9) !== 7) begin failures++; $display("FAIL stall_wr got n=%0d wr2=%b cyc=%0d exp 4/0/7", n_wr(9), lg_wr[2], first_rv(9)); end
      checks++; if ({ram[18'h183], ram[18'h182], ram[18'h181], ram[18'h180]} !== 32'h11223344) begin failures++; $display("FAIL stall_wram got %h exp 11223344", {ram[18'h183], ram[18'h182], ram[18'h181], ram[18'h180]}); end
   endtask

   task automatic test_flush();
      ctl_flush[2] = 1;
      xfer(0, 0, 2'd2, 0, 32'h40, 0, 9);
      checks++; if (n_rv(9) !== 0 || lg_a[3] !== 0) begin failures++; $display("FAIL flush_abort got n=%0d a3=%h exp 0/0", n_rv(9), lg_a[3]); end
      ctl_flush[0] = 1;
      xfer(0, 0, 2'd2, 0, 32'h0, 0, 8);
      checks++; if (lg_rdy[0] !== 1 || first_rv(8) !== 6) begin failures++; $display("FAIL flush_next got rdy=%b cyc=%0d exp 1/6", lg_rdy[0], first_rv(8)); end
      ctl_flush[6] = 1;
      xfer(0, 0, 2'd2, 0, 32'h0, 0, 9);
      checks++; if (n_rv(9) !== 0) begin failures++; $display("FAIL flush_resp got %0d pulses exp 0", n_rv(9)); end
      ctl_flush[1] = 1; ctl_flush[3] = 1;
      xfer(1, 0, 2'd0, 0, 32'h200, 0, 5);
      checks++; if (first_rv(5) !== 3 || lg_rd[3] !== 32'h80) begin failures++; $display("FAIL flush_ls got cyc=%0d d=%h exp 3/80", first_rv(5), lg_rd[3]); end
   endtask

   task automatic test_wrap();
      xfer(0, 0, 2'd2, 0, 32'hFFFFFFFE, 0, 8);
      checks++; if (lg_a[2] !== 32'hFFFFFFFF || lg_a[3] !== 0 || lg_a[4] !== 1) begin failures++; $display("FAIL wrap_addr got %h %h %h exp FFFFFFFF 0 1", lg_a[2], lg_a[3], lg_a[4]); end
      checks++; if (lg_rd[6] !== 32'h0513BBAA) begin failures++; $display("FAIL wrap_data got %h exp 0513BBAA", lg_rd[6]); end
   endtask

   task automatic test_misalign();
      xfer(1, 0, 2'd2, 0, 32'h101, 0, 8);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      checks++; if (first_rv(8) !== 1 || lg_err[1] !== 1 || lg_rd[1] !== 0) begin failures++; $display("FAIL mis_err got cyc=%0d err=%b d=%h exp 1/1/0", first_rv(8), lg_err[1], lg_rd[1]); end
      checks++; if (lg_a[1] !== 0 || lg_a[2] !== 0 || n_wr(8) !== 0) begin failures++; $display("FAIL mis_bus got a=%h %h nwr=%0d exp idle", lg_a[1], lg_a[2], n_wr(8)); end
`else
      checks++; if (first_rv(8) !== 6 || lg_rd[6] !== 32'h77DEADBE || lg_err[6] !== 0) begin failures++; $display("FAIL mis_plain got cyc=%0d d=%h err=%b exp 6/77DEADBE/0", first_rv(8), lg_rd[6], lg_err[6]); end
      checks++; if (lg_a[1] !== 32'h101 || lg_a[4] !== 32'h104) begin failures++; $display("FAIL mis_addr got %h %h exp 101 104", lg_a[1], lg_a[4]); end
`endif
   endtask

   initial begin
      clr_ctl();
      test_reset();
      poke(18'h0, 8'h13); poke(18'h1, 8'h05); poke(18'h2, 8'h00); poke(18'h3, 8'h00);
      poke(18'h40, 8'h11); poke(18'h41, 8'h22); poke(18'h42, 8'h33); poke(18'h43, 8'h44);
      poke(18'h200, 8'h80); poke(18'h104, 8'h77); poke(18'h3FFFE, 8'hAA); poke(18'h3FFFF, 8'hBB);
      test_if_fetch();
      test_store_load();
      test_io_wait();
      test_back_to_back();
      test_rdy_stall();
      test_flush();
      test_wrap();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
